// File: rtl/led_driver_pkg.sv
// rtl/led_driver_pkg.sv - shared types and constants for the LED driver register bus
package led_driver_pkg;

   localparam int DATA_BITS = 8;

   // Register map of led_controller
   typedef enum logic [3:0] {
      REG_MODE1   = 4'h0,
      REG_MODE2   = 4'h1,
      REG_PWM0    = 4'h2,
      REG_PWM1    = 4'h3,
      REG_PWM2    = 4'h4,
      REG_PWM3    = 4'h5,
      REG_GRPPWM  = 4'h6,
      REG_GRPFREQ = 4'h7,
      REG_LEDOUT  = 4'h8
   } reg_enum_t;

   localparam int ADDR_BITS = $bits(reg_enum_t);

   // Bus operation carried by each queued command
   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } bus_op_t;

   // Bus host sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } host_state_t;

   // One queued command
   typedef struct packed {
      bus_op_t                op;
      reg_enum_t              addr;
      logic [DATA_BITS-1:0]   data;
   } cmd_entry_t;

endpackage

// File: rtl/led_cmd_fifo.sv
// rtl/led_cmd_fifo.sv - synchronous command queue for the bus host
module led_cmd_fifo
   import led_driver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  cmd_entry_t               push_data,
   input  logic                     pop,
   output cmd_entry_t               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   cmd_entry_t            mem [DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr;
   logic [PTR_BITS-1:0]   rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // Full blocks a push even when a pop happens in the same cycle
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == CNT_BITS'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage needs no reset: entries are only read while counted as valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
      end
   end

endmodule

// File: rtl/led_bus_host.sv
// rtl/led_bus_host.sv - queued register-bus initiator toward led_controller
module led_bus_host #(
   parameter int DATA_BITS  = led_driver_pkg::DATA_BITS,
   parameter int ADDR_BITS  = led_driver_pkg::ADDR_BITS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_400K,
   input  logic                  reset,
   input  logic                  sleep,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [ADDR_BITS-1:0]  cmd_addr,
   input  logic [DATA_BITS-1:0]  cmd_data,
   output logic                  rsp_valid,
   output logic [ADDR_BITS-1:0]  rsp_addr,
   output logic [DATA_BITS-1:0]  rsp_data,
   output logic                  busy,
   output logic [ADDR_BITS-1:0]  bus_addr,
   inout  wire  [DATA_BITS-1:0]  bus_data,
   output logic                  bus_w_en,
   output logic                  bus_r_en
);

   import led_driver_pkg::*;

   host_state_t                  state;
   host_state_t                  state_next;
   cmd_entry_t                   push_entry;
   cmd_entry_t                   head;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic                         cmd_push;
   logic                         cmd_pop;
   bus_op_t                      cur_op;
   logic [DATA_BITS-1:0]         cur_data;

   assign cmd_ready  = !fifo_full;
   assign cmd_push   = cmd_valid && !fifo_full;
   assign push_entry = '{op: bus_op_t'(cmd_op), addr: reg_enum_t'(cmd_addr), data: cmd_data};

   // A new transaction may only start from IDLE or at the end of a strobe
   assign cmd_pop = ((state == IDLE) || (state == STROBE)) && !fifo_empty && !sleep;

   led_cmd_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_400K),
      .reset     (reset),
      .push      (cmd_push),
      .push_data (push_entry),
      .pop       (cmd_pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // State register
   always_ff @(posedge clk_400K or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: SETUP always leads to STROBE; STROBE chains straight into the next SETUP
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = cmd_pop ? SETUP : IDLE;
         SETUP:   state_next = STROBE;
         STROBE:  state_next = cmd_pop ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: strobes only in STROBE, so two strobes are always at least one cycle apart
   always_comb begin
      bus_w_en = 1'b0;
      bus_r_en = 1'b0;
      if (state == STROBE) begin
         bus_w_en = (cur_op == OP_WRITE);
         bus_r_en = (cur_op == OP_READ);
      end
      busy = (state != IDLE) || (fifo_count != '0);
   end

   // The host owns the data lines only during a write strobe
   assign bus_data = bus_w_en ? cur_data : {DATA_BITS{1'bz}};

   // Latch the popped command; bus_addr keeps its value between transactions
   always_ff @(posedge clk_400K or posedge reset) begin
      if (reset) begin
         cur_op   <= OP_WRITE;
         cur_data <= '0;
         bus_addr <= '0;
      end else if (cmd_pop) begin
         cur_op   <= head.op;
         cur_data <= head.data;
         bus_addr <= head.addr;
      end
   end

   // Read data is sampled on the edge that ends STROBE and presented for one cycle
   always_ff @(posedge clk_400K or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= (state == STROBE) && (cur_op == OP_READ);
         if ((state == STROBE) && (cur_op == OP_READ)) begin
            rsp_addr <= bus_addr;
            rsp_data <= bus_data;
         end
      end
   end

endmodule

// File: tb/tb_led_bus_host.sv
// tb/tb_led_bus_host.sv - scoreboard bench for led_bus_host with a behavioural register responder
module tb_led_bus_host;

   import led_driver_pkg::*;

   logic        clk_400K = 1'b0;
   logic        reset;
   logic        sleep;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [3:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic [3:0]  rsp_addr;
   logic [7:0]  rsp_data;
   logic        busy;
   logic [3:0]  bus_addr;
   wire  [7:0]  bus_data;
   logic        bus_w_en;
   logic        bus_r_en;

   always #5 clk_400K = ~clk_400K;

   led_bus_host dut (
      .clk_400K  (clk_400K),
      .reset     (reset),
      .sleep     (sleep),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_addr  (rsp_addr),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .bus_addr  (bus_addr),
      .bus_data  (bus_data),
      .bus_w_en  (bus_w_en),
      .bus_r_en  (bus_r_en)
   );

   // Responder standing in for led_controller; drives a marker pattern when idle
   logic [7:0] regs [16];
   logic [7:0] tb_val;

   always @(posedge clk_400K or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= (i == 6) ? 8'hFF : 8'h00;
      end else if (bus_w_en) begin
         regs[bus_addr] <= bus_data;
      end
   end

   always_comb tb_val = bus_r_en ? regs[bus_addr] : 8'hA5;
   assign bus_data = bus_w_en ? 8'hzz : tb_val;

   // Scoreboard
   typedef struct { logic op; logic [3:0] addr; logic [7:0] data; } bus_exp_t;
   typedef struct { logic [3:0] addr; logic [7:0] data; } rsp_exp_t;

   bus_exp_t bus_q[$];
   rsp_exp_t rsp_q[$];
   int       strobe_cyc[$];
   int       rsp_cyc[$];
   int       checks = 0;
   int       failures = 0;
   int       cyc = 0;
   int       acc = 0;
   logic     prev_strobe = 1'b0;
   logic [3:0] prev_addr = 4'h0;
   bus_exp_t mon_b;
   rsp_exp_t mon_r;

   always @(posedge clk_400K) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe or a response
   always @(negedge clk_400K) begin
      if (!bus_w_en) chk("host_releases_bus", bus_data, tb_val);
      if (bus_w_en || bus_r_en) begin
         chk("single_strobe", bus_w_en && bus_r_en, 0);
         chk("strobe_gap", prev_strobe, 0);
         chk("addr_setup", bus_addr, prev_addr);
         strobe_cyc.push_back(cyc);
         if (bus_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            mon_b = bus_q.pop_front();
            chk("bus_op", bus_r_en, mon_b.op);
            chk("bus_addr", bus_addr, mon_b.addr);
            if (bus_w_en) chk("bus_wdata", bus_data, mon_b.data);
         end
      end
      if (rsp_valid) begin
         rsp_cyc.push_back(cyc);
         if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
         end else begin
            mon_r = rsp_q.pop_front();
            chk("rsp_addr", rsp_addr, mon_r.addr);
            chk("rsp_data", rsp_data, mon_r.data);
         end
      end
      prev_strobe = bus_w_en || bus_r_en;
      prev_addr   = bus_addr;
   end

   task automatic send(input logic op, input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
      int n = 0;
      @(negedge clk_400K);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
      while (!cmd_ready && n < 200) begin
         @(negedge clk_400K);
         n++;
      end
      chk("accept_timeout", cmd_ready, 1);
      if (cmd_ready) begin
         @(posedge clk_400K);
         #1;
         acc = cyc;
         bus_q.push_back('{op, a, d});
         if (op) rsp_q.push_back('{a, exp_rd});
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk_400K);
         n++;
      end while (busy && n < 300);
      chk("idle_timeout", busy, 0);
      repeat (3) @(negedge clk_400K);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; sleep = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 4'h0; cmd_data = 8'h00;
      repeat (3) @(posedge clk_400K);
      @(negedge clk_400K);
      chk("rst_w_en", bus_w_en, 0);
      chk("rst_r_en", bus_r_en, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_addr", rsp_addr, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk_400K);
      chk("cmd_ready_after_rst", cmd_ready, 1);

      // Write then read, with latency checks
      strobe_cyc.delete();
      send(1'b0, REG_PWM0, 8'h40, 8'h00);
      n = acc;
      wait_idle();
      chk("wr_strobe_count", strobe_cyc.size(), 1);
      if (strobe_cyc.size() > 0) chk("wr_strobe_cycle", strobe_cyc[0], n + 2);
      rsp_cyc.delete();
      send(1'b1, REG_PWM0, 8'h00, 8'h40);
      n = acc;
      wait_idle();
      chk("rd_rsp_count", rsp_cyc.size(), 1);
      if (rsp_cyc.size() > 0) chk("rd_rsp_cycle", rsp_cyc[0], n + 3);

      // Back-to-back writes, then read back
      strobe_cyc.delete();
      send(1'b0, REG_PWM0, 8'h40, 8'h00);
      send(1'b0, REG_PWM1, 8'h80, 8'h00);
      send(1'b0, REG_PWM2, 8'hC0, 8'h00);
      send(1'b0, REG_PWM3, 8'hFF, 8'h00);
      wait_idle();
      chk("b2b_strobe_count", strobe_cyc.size(), 4);
      if (strobe_cyc.size() == 4)
         for (int i = 1; i < 4; i++) chk("b2b_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
      send(1'b1, REG_PWM0, 8'h00, 8'h40);
      send(1'b1, REG_PWM1, 8'h00, 8'h80);
      send(1'b1, REG_PWM2, 8'h00, 8'hC0);
      send(1'b1, REG_PWM3, 8'h00, 8'hFF);
      wait_idle();

      // Queue full while asleep
      strobe_cyc.delete();
      @(negedge clk_400K);
      sleep = 1'b1;
      send(1'b0, REG_PWM0, 8'h11, 8'h00);
      send(1'b0, REG_PWM1, 8'h22, 8'h00);
      send(1'b0, REG_PWM2, 8'h33, 8'h00);
      send(1'b1, REG_PWM0, 8'h00, 8'h11);
      @(negedge clk_400K);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = REG_PWM1; cmd_data = 8'h00;
      repeat (5) begin
         chk("full_cmd_ready", cmd_ready, 0);
         chk("full_busy", busy, 1);
         @(negedge clk_400K);
      end
      chk("asleep_no_strobe", strobe_cyc.size(), 0);
      sleep = 1'b0;
      send(1'b1, REG_PWM1, 8'h00, 8'h22);
      wait_idle();

      // Sleep asserted during the strobe of the 2nd of three reads
      send(1'b1, REG_PWM0, 8'h00, 8'h11);
      send(1'b1, REG_PWM1, 8'h00, 8'h22);
      send(1'b1, REG_PWM2, 8'h00, 8'h33);
      n = 0;
      while (!(bus_r_en && bus_addr == REG_PWM1) && n < 50) begin
         @(negedge clk_400K);
         n++;
      end
      chk("found_2nd_strobe", (n < 50), 1);
      sleep = 1'b1;
      repeat (6) begin
         @(negedge clk_400K);
         chk("sleep_busy", busy, 1);
      end
      chk("sleep_3rd_queued", bus_q.size(), 1);
      chk("sleep_rsp_drained", rsp_q.size(), 1);
      sleep = 1'b0;
      wait_idle();

      // Reset during SETUP of a write
      send(1'b0, REG_GRPPWM, 8'h20, 8'h00);
      @(negedge clk_400K);
      @(negedge clk_400K);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_w_en", bus_w_en, 0);
      chk("mid_rst_r_en", bus_r_en, 0);
      chk("mid_rst_bus_addr", bus_addr, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_data", rsp_data, 0);
      chk("mid_rst_rsp_addr", rsp_addr, 0);
      chk("mid_rst_busy", busy, 0);
      if (bus_q.size() > 0) void'(bus_q.pop_back());
      strobe_cyc.delete();
      @(negedge clk_400K);
      @(negedge clk_400K);
      reset = 1'b0;
      repeat (5) @(negedge clk_400K);
      chk("no_strobe_after_rst", strobe_cyc.size(), 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      send(1'b1, REG_GRPPWM, 8'h00, 8'hFF);
      wait_idle();

      chk("bus_q_drained", bus_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_bus_host.md
# led_bus_host

Register-bus initiator for the LED driver. It accepts write and read commands from a local requester through a valid/ready queue and converts each one into a bus_if transaction toward led_controller. Each transaction drives addr, then pulses w_en or r_en for exactly one clk_400K cycle. Read data is returned on a one-cycle response strobe. The block sits between any sequencing/host logic and led_controller's register bus, on the same 400 kHz clock.

## Interface
- DATA_BITS, 8 (from led_driver_pkg): bus data width.
- ADDR_BITS, $bits(reg_enum_t): bus address width.
- FIFO_DEPTH, 4: command queue entries; power of two, minimum 2.

Ports (name, direction, width, meaning):
- clk_400K  in  1  the only clock, rising edge.
- reset  in  1  asynchronous, active-high.
- sleep  in  1  high: no new bus transaction starts.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept; equals !full.
- cmd_op  in  1  bus_op_t: OP_WRITE=0, OP_READ=1.
- cmd_addr  in  ADDR_BITS  target register.
- cmd_data  in  DATA_BITS  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rsp_addr  out  ADDR_BITS  address of the completed read.
- rsp_data  out  DATA_BITS  captured read data.
- busy  out  1  FSM not IDLE or queue non-empty.
- bus_addr  out  ADDR_BITS  bus address.
- bus_data  inout  DATA_BITS  driven only while bus_w_en=1, else 'z.
- bus_w_en  out  1  write strobe.
- bus_r_en  out  1  read strobe.

## Operation
- A command is accepted on a rising edge with cmd_valid && cmd_ready and is pushed into the FIFO. The FIFO has no pass-through: when full, cmd_ready is low and a simultaneous pop does not free a slot that cycle.
- FSM states: IDLE, SETUP, STROBE.
- IDLE -> SETUP: FIFO non-empty and sleep=0. The head is popped and its op, addr and data are latched.
- SETUP: bus_addr is driven with the latched address. Both strobes are 0.
- SETUP -> STROBE: unconditional. In STROBE, bus_w_en=1 for a write or bus_r_en=1 for a read, for exactly one cycle. bus_addr is held.
- STROBE -> SETUP: FIFO non-empty and sleep=0; pops the next entry. Otherwise STROBE -> IDLE.
- Read completion: bus_data is sampled on the edge that ends STROBE. On the next cycle, rsp_data and rsp_addr are updated and rsp_valid=1 for one cycle. There is no rsp_ready; the consumer must take the response on the pulse.
- Write completion produces no response.
- bus_addr holds its last value between transactions.
- sleep is checked only at the IDLE/STROBE exit decision. A transaction in flight always completes, and the FIFO keeps accepting commands while asleep.
- Reset, asynchronous, at any time, including mid-transaction:
  - FIFO emptied, FSM to IDLE.
  - bus_w_en=0, bus_r_en=0, bus_addr=0, bus_data='z.
  - rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0.
  - cmd_ready=1 once reset is released.
  - An aborted transaction is not replayed.

## Timing
- Edge 0 accepts the command into an empty FIFO with the FSM in IDLE.
- Cycle 1 (after edge 1): SETUP, address valid.
- Cycle 2: STROBE, strobe high.
- Cycle 3: rsp_valid high (reads only).
- Sustained throughput: one transaction per 2 cycles with no idle gap while the FIFO is non-empty.
- The address is stable for at least one full cycle before and during the strobe. No strobe is ever asserted in two consecutive cycles.

## Structure
- led_driver_pkg additions: bus_op_t enum, host_state_t enum (IDLE/SETUP/STROBE), and a cmd_entry_t packed struct {op, addr, data}.
- One sub-module: led_cmd_fifo, a synchronous FIFO with parameter DEPTH, an element of type cmd_entry_t, and full/empty flags plus a count. The FSM, tristate driver and response register live in led_bus_host.

## Test plan
- Write then read, with led_controller as the responder:
  - Stimulus: write REG_PWM0 = 8'h40, then read REG_PWM0.
  - Required: bus_w_en pulses in cycle 2 after acceptance; rsp_valid pulses with rsp_addr=REG_PWM0, rsp_data=8'h40.
- Back-to-back writes:
  - Stimulus: four writes queued, PWM0..PWM3 = 40/80/C0/FF.
  - Required: strobes exactly 2 cycles apart; all four values read back correctly.
- Queue full:
  - Stimulus: five commands offered with sleep=1.
  - Required: cmd_ready drops after the 4th; no bus activity. After sleep drops, the four commands complete in order and the 5th is then accepted.
- Sleep mid-stream:
  - Stimulus: assert sleep during the STROBE of the 2nd of three reads.
  - Required: the 2nd completes with its rsp_valid; the 3rd stays queued and busy=1 until sleep=0.
- Reset mid-transaction:
  - Stimulus: assert reset during SETUP of a write of REG_GRPPWM = 8'h20.
  - Required: all outputs at reset values immediately; no strobe follows; a later read of REG_GRPPWM returns led_controller's reset value.
- Tristate check:
  - Required: bus_data is 'z from the host in every cycle where bus_w_en=0, including during reads.
